hs_sync_sink: RTL
=================

Name: hs_sync_sink

Overview:
- Clocked receiving end of the self-timed Send/Ack stage chain: the synchronous consumer a C-element pipeline stage hands its tokens to.
- Synchronises Send_in, captures the bundled Data_in into a small FIFO and returns Ack_out. The sender's stage is released only once the word is stored.
- Presents the words to clocked logic with a valid/ready interface.
- Default protocol: 2-phase (transition) signalling.

Parameters:
- DATA_W, 32, width of the bundled data word.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flops in the Send_in synchroniser; at least 2.

Ports:
- CLK  in  1  single clock.
- MR  in  1  master reset; synchronous, active-low.
- Send_in  in  1  request from the self-timed stage; asynchronous to CLK.
- Data_in  in  DATA_W  bundled data; stable from before a Send_in event until the matching Ack_out event.
- Ack_out  out  1  acknowledge to the self-timed stage; registered.
- Dout  out  DATA_W  head-of-FIFO word.
- Dout_valid  out  1  FIFO not empty.
- Dout_ready  in  1  consumer accepts Dout when Dout_valid=1.
- Count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (MR=0 at a rising edge):
  - Ack_out=0, synchroniser flops=0, FIFO empty, Count=0, Dout_valid=0, FSM=IDLE.
  - Dout is don't-care while Dout_valid=0.
- Let send_s be the synchronised Send_in, taken from the last synchroniser stage.
- 2-phase mode:
  - A token is pending when send_s != Ack_out.
  - At an edge with a pending token and Count<DEPTH: write Data_in to wr_ptr and toggle Ack_out, in the same edge.
  - Data_in is sampled only at that edge. SYNC_STAGES of delay guarantee the bundled data has settled.
- Latency: Send_in toggles before edge k. With SYNC_STAGES=2, send_s updates at edge k+1, capture and the Ack_out toggle happen at edge k+2, and Dout_valid=1 in the cycle after edge k+2 (first-word fall-through).
- Full (Count==DEPTH):
  - No capture; Ack_out holds, so the sender stalls.
  - Capture resumes at the first edge where Count<DEPTH at the start of the cycle.
  - A pop in the same cycle does not enable a push; there is no pass-through while full.
- Pop: Dout_valid && Dout_ready at an edge advances rd_ptr.
- Push and pop in the same edge with 0<Count<DEPTH: Count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count tracks occupancy exactly, range 0..DEPTH.
- Reset mid-operation: pending or stored words are discarded. If Send_in=1 when MR releases, send_s becomes 1 and is treated as a pending token (captured normally). The system must reset sender and sink together.
- At most one capture per 2*SYNC_STAGES... no faster than synchroniser delay allows: one token per Ack round trip.
- FSM (2-phase): IDLE (no token) -> IDLE with Ack toggled on capture; IDLE -> STALL when a token is pending and the FIFO is full; STALL -> IDLE on capture.

Optional Feature:
- Macro: HS_4PHASE_EN.
- Defined: 4-phase return-to-zero protocol, with FSM IDLE -> ACK_HI -> IDLE.
  - IDLE: send_s=1 and not full -> capture, Ack_out=1, go to ACK_HI.
  - ACK_HI: wait for send_s=0, then Ack_out=0 and go to IDLE.
  - A full FIFO holds the FSM in IDLE with Ack_out=0.
- Undefined: 2-phase behaviour as above. The ACK_HI state is not built.

Decomposition:
- Package ddp_hs_pkg holds:
  - the FSM state typedef (IDLE, STALL, ACK_HI);
  - default DATA_W;
  - the localparam helper for Count width.
- One sub-module, hs_sync: an N-flop synchroniser with parameter SYNC_STAGES and a reset value of 0, instantiated for Send_in.

Test Plan:
- Reset: MR=0 for 3 cycles with Send_in=0 -> Ack_out=0, Dout_valid=0, Count=0.
- Single token: toggle Send_in 0->1 with Data_in=32'hA5A5_0001 before edge k -> Ack_out=1 after edge k+2; Dout=32'hA5A5_0001 and Dout_valid=1 in the next cycle.
- Fill to full: Dout_ready=0, send 5 tokens with DEPTH=4 -> Count=4 and 4 Ack toggles; the 5th toggle waits. Pulse Dout_ready for 1 cycle -> 5th captured one edge later, Count=4.
- Streaming: Dout_ready=1 with back-to-back tokens 1..16 -> words out in order, no loss or duplication, Count never exceeds 2.
- Reset mid-stream: MR=0 with Count=3 and Send_in=1 -> Count=0 and Ack_out=0. After release, one token is captured and Ack_out=1.
- HS_4PHASE_EN: Send_in raised -> Ack_out=1 after 2 edges; Send_in lowered -> Ack_out=0 after 2 edges; exactly one word is stored.

Source files
------------

// File: rtl/ddp_hs_pkg.sv
// Shared types and helpers for the Send/Ack handshake sink.
package ddp_hs_pkg;

   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STALL  = 2'd1,
      ACK_HI = 2'd2
   } hs_state_e;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hs_sync.sv
// N-flop synchroniser for a single asynchronous level; all stages reset to 0.
module hs_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hs_sync_sink.sv
// Clocked sink for a self-timed Send/Ack chain: synchronise Send_in, store Data_in, return Ack_out.
// HS_4PHASE_EN selects 4-phase return-to-zero signalling; default is 2-phase transition signalling.
module hs_sync_sink
   import ddp_hs_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                      CLK,
   input  logic                      MR,
   input  logic                      Send_in,
   input  logic [DATA_W-1:0]         Data_in,
   output logic                      Ack_out,
   output logic [DATA_W-1:0]         Dout,
   output logic                      Dout_valid,
   input  logic                      Dout_ready,
   output logic [cnt_w(DEPTH)-1:0]   Count
);

   localparam int unsigned CNT_W = cnt_w(DEPTH);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic              send_s;
   hs_state_e         state_q, state_d;
   logic              ack_q, ack_d;
   logic              push_c, pop_c, full_c;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   hs_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_send_sync (
      .clk_i  (CLK),
      .rst_ni (MR),
      .d_i    (Send_in),
      .q_o    (send_s)
   );

   // Fullness is judged on the start-of-cycle count: a pop never frees a slot for the same edge.
   assign full_c = (count_q == CNT_W'(DEPTH));
   assign pop_c  = Dout_valid && Dout_ready;

`ifndef HS_4PHASE_EN
   logic pending_c;
   assign pending_c = send_s ^ ack_q;
`endif

   always_ff @(posedge CLK) begin
      if (!MR) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
`ifdef HS_4PHASE_EN
      case (state_q)
         IDLE:    if (send_s && !full_c) state_d = ACK_HI;
         ACK_HI:  if (!send_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
`else
      case (state_q)
         IDLE, STALL: state_d = (pending_c && full_c) ? STALL : IDLE;
         default:     state_d = IDLE;
      endcase
`endif
   end

   always_comb begin
      push_c = 1'b0;
      ack_d  = ack_q;
`ifdef HS_4PHASE_EN
      case (state_q)
         IDLE: begin
            if (send_s && !full_c) begin
               push_c = 1'b1;
               ack_d  = 1'b1;
            end
         end
         ACK_HI:  if (!send_s) ack_d = 1'b0;
         default: ack_d = 1'b0;
      endcase
`else
      case (state_q)
         IDLE, STALL: begin
            if (pending_c && !full_c) begin
               push_c = 1'b1;
               ack_d  = ~ack_q;
            end
         end
         default: ack_d = ack_q;
      endcase
`endif
   end

   always_comb begin
      wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!MR) begin
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         ack_q    <= ack_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge CLK) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= Data_in;
      end
   end

   assign Ack_out    = ack_q;
   assign Dout       = mem_q[rd_ptr_q];
   assign Dout_valid = (count_q != '0);
   assign Count      = count_q;

endmodule
